// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ITER_N = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ACC_W  = 2 * WORD_W;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Per-operation context captured when a start is accepted.
    typedef struct packed {
        logic              is_div;
        logic              neg_res;
        logic              neg_rem;
        logic              div_zero;
        logic [WORD_W-1:0] b_mag;
    } op_ctx_t;

    // Absolute value of a word when treated as signed, pass-through otherwise.
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                     input logic              is_signed);
        return (is_signed && v[WORD_W-1]) ? (WORD_W'(0) - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic              start_i;
    logic [1:0]        op_i;
    logic [WORD_W-1:0] rs_data_i;
    logic [WORD_W-1:0] rt_data_i;
    logic              hilo_we_i;
    logic              hilo_sel_i;
    logic [WORD_W-1:0] hilo_wdata_i;
    logic              busy_o;
    logic              done_o;
    logic              div_zero_o;
    logic [WORD_W-1:0] hi_o;
    logic [WORD_W-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_data_i, rt_data_i,
        output hilo_we_i, hilo_sel_i, hilo_wdata_i,
        input  busy_o, done_o, div_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_data_i, rt_data_i,
        input  hilo_we_i, hilo_sel_i, hilo_wdata_i,
        output busy_o, done_o, div_zero_o, hi_o, lo_o
    );

endinterface

// File: rtl/mult_div_unit_step_core.sv
// One iteration of shift-add multiply or restoring divide on a 64-bit accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}, b_i is the multiplicand.
// Divide:   acc = {partial remainder, dividend/quotient bits}, b_i is the divisor.
module mdu_step_core
    import mult_div_unit_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [WORD_W-1:0] b_i,
    input  step_mode_e        mode_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [WORD_W:0] sum;
    logic [WORD_W:0] diff;

    // Next accumulator for the selected operation.
    always_comb begin
        sum   = {1'b0, acc_i[ACC_W-1:WORD_W]} + {1'b0, b_i};
        diff  = acc_i[ACC_W-1:WORD_W-1] - {1'b0, b_i};
        acc_o = acc_i;
        if (mode_i == STEP_MUL) begin
            acc_o = acc_i[0] ? {sum, acc_i[WORD_W-1:1]}
                             : {1'b0, acc_i[ACC_W-1:1]};
        end else begin
            // diff MSB set means the shifted remainder was below the divisor.
            acc_o = diff[WORD_W] ? {acc_i[ACC_W-2:0], 1'b0}
                                 : {diff[WORD_W-1:0], acc_i[WORD_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// busy_o/done_o/div_zero_o are registered from the current state, so they
// trail the state by one cycle: busy covers 33 cycles, done follows on the next.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    op_ctx_t           ctx_q, ctx_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    op_e               op_in;
    logic              signed_op;
    logic [WORD_W-1:0] a_mag;
    logic [WORD_W-1:0] b_mag;
    logic [ACC_W-1:0]  acc_step;
    logic [ACC_W-1:0]  prod_fix;
    logic [WORD_W-1:0] quot_fix;
    logic [WORD_W-1:0] rem_fix;

    mdu_step_core u_step (
        .acc_i  (acc_q),
        .b_i    (ctx_q.b_mag),
        .mode_i (ctx_q.is_div ? STEP_DIV : STEP_MUL),
        .acc_o  (acc_step)
    );

    // Operand decode at the input and sign correction of the finished accumulator.
    always_comb begin
        op_in     = op_e'(bus.op_i);
        signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
        a_mag     = magnitude(bus.rs_data_i, signed_op);
        b_mag     = magnitude(bus.rt_data_i, signed_op);
        prod_fix  = ctx_q.neg_res ? (ACC_W'(0) - acc_q) : acc_q;
        quot_fix  = ctx_q.neg_res ? (WORD_W'(0) - acc_q[WORD_W-1:0])
                                  : acc_q[WORD_W-1:0];
        rem_fix   = ctx_q.neg_rem ? (WORD_W'(0) - acc_q[ACC_W-1:WORD_W])
                                  : acc_q[ACC_W-1:WORD_W];
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ctx_d   = ctx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = (state_q == ST_CALC) || (state_q == ST_FIX);
        done_d  = (state_q == ST_DONE);
        dz_d    = (state_q == ST_DONE) && ctx_q.div_zero;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    // Start wins over a simultaneous direct HI/LO write.
                    state_d        = ST_CALC;
                    cnt_d          = '0;
                    acc_d          = {{WORD_W{1'b0}}, a_mag};
                    ctx_d.is_div   = op_in[1];
                    ctx_d.neg_res  = signed_op && (bus.rs_data_i[WORD_W-1] ^ bus.rt_data_i[WORD_W-1]);
                    ctx_d.neg_rem  = (op_in == OP_DIV) && bus.rs_data_i[WORD_W-1];
                    ctx_d.div_zero = op_in[1] && (bus.rt_data_i == '0);
                    ctx_d.b_mag    = b_mag;
                end else if (bus.hilo_we_i) begin
                    if (bus.hilo_sel_i) begin
                        hi_d = bus.hilo_wdata_i;
                    end else begin
                        lo_d = bus.hilo_wdata_i;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (!ctx_q.div_zero) begin
                    if (ctx_q.is_div) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[ACC_W-1:WORD_W];
                        lo_d = prod_fix[WORD_W-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ctx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ctx_q   <= ctx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.div_zero_o = dz_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

endmodule
